// File: rtl/merge_row_seq.sv
// Sequenced merge row: collects R beats of two sorted N-key lists and merges each slot in place with a
// registered Batcher odd-even merge, one level per clock. Optional macro SORT_DESCEND_EN selects descending order.
module merge_row_seq #(
  parameter int WIDTH = 8,
  parameter int N     = 2,
  parameter int R     = 4,
  localparam int SW   = $clog2(R + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*N*WIDTH-1:0]     inba,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*N*R*WIDTH-1:0]   c,
  output logic [SW-1:0]            slot_cnt
);

  localparam int L  = $clog2(2 * N);
  localparam int LW = (L > 1) ? $clog2(L) : 1;

`ifdef SORT_DESCEND_EN
  localparam logic [WIDTH-1:0] PAD_KEY = {WIDTH{1'b0}};
`else
  localparam logic [WIDTH-1:0] PAD_KEY = {WIDTH{1'b1}};
`endif

  typedef logic [2*N-1:0][WIDTH-1:0] row_t;
  typedef enum logic [1:0] {FILL = 2'd0, MERGE = 2'd1, HOLD = 2'd2} state_t;

  state_t          state_q, state_d;
  row_t [R-1:0]    slots_q, slots_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   level_q, level_d;
  logic            accept_s, last_s, close_s;
  logic [SW-1:0]   fill_cnt_s;

  // Level lv pairs (a, a+k), k = N>>lv, in blocks of k starting at 0 (first level) or k (later levels).
  function automatic logic in_level(input int lv, input int a, input int b);
    int k, j0;
    k  = N >> lv;
    j0 = (k == N) ? 0 : k;
    return ((b - a) == k) && (a >= j0) && (((a - j0) % (2 * k)) < k);
  endfunction

  function automatic row_t merge_level(input row_t row_in, input int lv);
    row_t             r;
    logic             swap;
    logic [WIDTH-1:0] lo, hi;
    r = row_in;
    for (int a = 0; a < 2 * N; a++) begin
      for (int b = a + 1; b < 2 * N; b++) begin
        if (in_level(lv, a, b)) begin
`ifdef SORT_DESCEND_EN
          swap = (r[a] < r[b]);
`else
          swap = (r[a] > r[b]);
`endif
          lo   = swap ? r[b] : r[a];
          hi   = swap ? r[a] : r[b];
          r[a] = lo;
          r[b] = hi;
        end
      end
    end
    return r;
  endfunction

  assign accept_s   = in_valid && (state_q == FILL);
  assign last_s     = accept_s && (cnt_q == SW'(R - 1));
  assign close_s    = (state_q == FILL) && flush && !last_s && ((cnt_q != '0) || accept_s);
  assign fill_cnt_s = cnt_q + SW'(accept_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    state_d = (last_s || close_s) ? MERGE : FILL;
      MERGE:   state_d = (level_q == LW'(L - 1)) ? HOLD : MERGE;
      HOLD:    state_d = out_ready ? FILL : HOLD;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == FILL);
    out_valid = (state_q == HOLD);
  end

  always_comb begin
    slots_d = slots_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      FILL: begin
        level_d = '0;
        cnt_d   = fill_cnt_s;
        // Slots at or beyond the real count are padded when a short row is closed.
        for (int s = 0; s < R; s++) begin
          if (accept_s && (cnt_q == SW'(s))) slots_d[s] = inba;
          else if (close_s && (SW'(s) >= fill_cnt_s)) slots_d[s] = {2*N{PAD_KEY}};
          else slots_d[s] = slots_q[s];
        end
      end
      MERGE: begin
        level_d = (level_q == LW'(L - 1)) ? '0 : level_q + 1'b1;
        for (int lv = 0; lv < L; lv++) begin
          if (level_q == LW'(lv)) begin
            for (int s = 0; s < R; s++) slots_d[s] = merge_level(slots_q[s], lv);
          end else begin
            slots_d = slots_d;
          end
        end
      end
      HOLD:    cnt_d = out_ready ? '0 : cnt_q;
      default: begin
        cnt_d   = '0;
        level_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots_q <= '0;
      cnt_q   <= '0;
      level_q <= '0;
    end else begin
      slots_q <= slots_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign c        = slots_q;
  assign slot_cnt = cnt_q;

endmodule

// File: tb/tb_merge_row_seq.sv
// Directed bench for merge_row_seq (WIDTH=8, N=2, R=4, ascending build).
module tb_merge_row_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  inba;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] c;
  logic [2:0]   slot_cnt;

  int passed = 0;
  int total  = 0;

  // Beats as {b1,b0,a1,a0}; sorted slots as {k3,k2,k1,k0}
  localparam logic [31:0] B0 = 32'h03020501;  // a={1,5} b={2,3}
  localparam logic [31:0] B1 = 32'h07040900;  // a={0,9} b={4,7}
  localparam logic [31:0] B2 = 32'h06060606;
  localparam logic [31:0] B3 = 32'h02010908;  // a={8,9} b={1,2}
  localparam logic [31:0] B4 = 32'h03020807;  // a={7,8} b={2,3}
  localparam logic [31:0] S0 = 32'h05030201;
  localparam logic [31:0] S1 = 32'h09070400;
  localparam logic [31:0] S2 = 32'h06060606;
  localparam logic [31:0] S3 = 32'h09080201;
  localparam logic [31:0] S4 = 32'h08070302;
  localparam logic [31:0] PD = 32'hFFFFFFFF;
  localparam logic [127:0] ROW1 = {S3, S2, S1, S0};
  localparam logic [127:0] ROW2 = {PD, PD, S1, S0};
  localparam logic [127:0] ROW3 = {PD, PD, PD, S4};

  merge_row_seq #(.WIDTH(8), .N(2), .R(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inba(inba),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .c(c), .slot_cnt(slot_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic fl);
    in_valid = 1'b1;
    inba     = d;
    flush    = fl;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; inba = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_slot_cnt", 128'(slot_cnt), 128'(3'd0));
    chk("rst_c", c, 128'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));

    // Full row; MERGE ignores in_valid, flush and out_ready
    beat(B0, 1'b0);
    chk("t1_cnt1", 128'(slot_cnt), 128'(3'd1));
    beat(B1, 1'b0);
    beat(B2, 1'b0);
    beat(B3, 1'b0);
    chk("t1_merge_ready", 128'({in_ready, out_valid}), 128'(2'b00));
    in_valid = 1'b1; inba = 32'hDEADBEEF; flush = 1'b1; out_ready = 1'b1;
    tick();
    chk("t1_lvl1_valid", 128'(out_valid), 128'(1'b0));
    tick();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    chk("t1_valid", 128'({out_valid, in_ready}), 128'(2'b10));
    chk("t1_c", c, ROW1);
    chk("t1_cnt", 128'(slot_cnt), 128'(3'd4));

    // Backpressure in HOLD
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold", {c[125:0], out_valid, in_ready}, {ROW1[125:0], 1'b1, 1'b0});
    end
    handoff();
    chk("t3_after_ready", 128'({in_ready, out_valid}), 128'(2'b10));
    chk("t3_after_cnt", 128'(slot_cnt), 128'(3'd0));
    chk("t3_c_kept", c, ROW1);

    // Partial row closed by flush
    beat(B0, 1'b0);
    beat(B1, 1'b0);
    chk("t2_cnt2", 128'(slot_cnt), 128'(3'd2));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t2_merge", 128'({in_ready, out_valid, slot_cnt}), 128'({2'b00, 3'd2}));
    tick();
    chk("t2_lvl1_valid", 128'(out_valid), 128'(1'b0));
    tick();
    chk("t2_valid", 128'(out_valid), 128'(1'b1));
    chk("t2_c", c, ROW2);
    chk("t2_cnt", 128'(slot_cnt), 128'(3'd2));
    handoff();

    // Flush on an empty row is ignored; flush with the final beat adds no padding
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_empty_flush", 128'({in_ready, out_valid, slot_cnt}), 128'({2'b10, 3'd0}));
    beat(B0, 1'b0);
    beat(B1, 1'b0);
    beat(B2, 1'b0);
    beat(B3, 1'b1);
    tick();
    tick();
    chk("t4_valid", 128'(out_valid), 128'(1'b1));
    chk("t4_c", c, ROW1);
    chk("t4_cnt", 128'(slot_cnt), 128'(3'd4));
    handoff();

    // Flush together with the first beat: beat stored, remaining slots padded
    beat(B4, 1'b1);
    tick();
    tick();
    chk("t4b_valid", 128'(out_valid), 128'(1'b1));
    chk("t4b_c", c, ROW3);
    chk("t4b_cnt", 128'(slot_cnt), 128'(3'd1));
    handoff();

    // Asynchronous reset at merge level 1
    beat(B0, 1'b0);
    beat(B1, 1'b0);
    beat(B2, 1'b0);
    beat(B3, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("t5_out_valid", 128'(out_valid), 128'(1'b0));
    chk("t5_cnt", 128'(slot_cnt), 128'(3'd0));
    chk("t5_c", c, 128'd0);
    #2;
    rst = 1'b0;
    tick();
    chk("t5_after", 128'({in_ready, out_valid, slot_cnt}), 128'({2'b10, 3'd0}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
